// File: rtl/vector_checker_if.sv
// Host/chip-side signal bundle for vector_checker: table load port, run
// control, chip stimulus/response pins and the result outputs.
interface vector_checker_if #(
    parameter int N_IN   = 1,
    parameter int N_OUT  = 1,
    parameter int ADDR_W = 2,
    parameter int ERR_W  = 8
);
    logic              Load;
    logic [ADDR_W-1:0] LoadAddr;
    logic [N_IN-1:0]   StimIn;
    logic [N_IN-1:0]   SMaskIn;
    logic [N_OUT-1:0]  ExpIn;
    logic [N_OUT-1:0]  EMaskIn;
    logic [ADDR_W-1:0] LastAddr;
    logic              Start;
    logic [N_IN-1:0]   A;
    logic [N_OUT-1:0]  Q;
    logic              Busy;
    logic              Done;
    logic              Pass;
    logic [ERR_W-1:0]  ErrCount;
    logic [N_OUT-1:0]  ErrBits;
    logic              FailValid;
    logic [ADDR_W-1:0] FirstFail;

    // Host and chip-under-test side
    modport master (
        output Load, LoadAddr, StimIn, SMaskIn, ExpIn, EMaskIn, LastAddr, Start, Q,
        input  A, Busy, Done, Pass, ErrCount, ErrBits, FailValid, FirstFail
    );

    // Checker side
    modport slave (
        input  Load, LoadAddr, StimIn, SMaskIn, ExpIn, EMaskIn, LastAddr, Start, Q,
        output A, Busy, Done, Pass, ErrCount, ErrBits, FailValid, FirstFail
    );
endinterface

// File: rtl/vector_checker.sv
// On-chip vector checker: applies table stimulus to the chip pins, samples
// the response after a settle interval, compares under mask and accumulates
// saturating error counts, sticky error bits and the first failing index.
module vector_checker #(
    parameter int N_IN      = 1,
    parameter int N_OUT     = 1,
    parameter int ADDR_W    = 2,
    parameter int SETTLE    = 4,
    parameter int HOLD      = 4,
    parameter int ERR_W     = 8,
    parameter int MASK_STIM = 0
) (
    input  logic           Clock,
    input  logic           nReset,
    vector_checker_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CMAX  = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int CNT_W = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
    localparam int PC_W  = $clog2(N_OUT + 1);
    localparam int SUM_W = ERR_W + PC_W;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_DONE} state_t;

    // Vector table; deliberately has no reset so it survives nReset
    logic [N_IN-1:0]  stim_mem  [DEPTH];
    logic [N_IN-1:0]  smask_mem [DEPTH];
    logic [N_OUT-1:0] exp_mem   [DEPTH];
    logic [N_OUT-1:0] emask_mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [N_IN-1:0]   a_q, a_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_OUT-1:0]  bits_q, bits_d;
    logic              fv_q, fv_d;
    logic [ADDR_W-1:0] ff_q, ff_d;

    logic              busy;
    logic [N_OUT-1:0]  diff;
    logic [PC_W-1:0]   pop;
    logic [SUM_W-1:0]  sum;
    logic [ERR_W-1:0]  err_sat;
    logic [N_IN-1:0]   stim0, smask0;
    logic [ADDR_W-1:0] idx_nxt;

    function automatic logic [N_IN-1:0] drive(input logic [N_IN-1:0] s, input logic [N_IN-1:0] m);
        return (MASK_STIM != 0) ? (s & m) : s;
    endfunction

    assign busy    = (state_q == S_SETTLE) || (state_q == S_HOLD);
    assign idx_nxt = idx_q + ADDR_W'(1);

    // Entry 0 is forwarded so a Load and Start in the same cycle run the new data
    assign stim0  = (bus.Load && bus.LoadAddr == '0) ? bus.StimIn  : stim_mem[0];
    assign smask0 = (bus.Load && bus.LoadAddr == '0) ? bus.SMaskIn : smask_mem[0];

    // Table write port, locked out while a run is in progress
    always_ff @(posedge Clock) begin
        if (bus.Load && !busy) begin
            stim_mem[bus.LoadAddr]  <= bus.StimIn;
            smask_mem[bus.LoadAddr] <= bus.SMaskIn;
            exp_mem[bus.LoadAddr]   <= bus.ExpIn;
            emask_mem[bus.LoadAddr] <= bus.EMaskIn;
        end
    end

    // Masked mismatch of the current vector and saturating error-count update
    always_comb begin
        diff = (bus.Q ^ exp_mem[idx_q]) & emask_mem[idx_q];
        pop  = '0;
        for (int i = 0; i < N_OUT; i++) pop = pop + PC_W'(diff[i]);
        sum     = SUM_W'(err_q) + SUM_W'(pop);
        err_sat = (sum > SUM_W'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
    end

    // Run sequencing: next state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        a_d     = a_q;
        err_d   = err_q;
        bits_d  = bits_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    err_d   = '0;
                    bits_d  = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    last_d  = bus.LastAddr;
                    idx_d   = '0;
                    cnt_d   = '0;
                    a_d     = drive(stim0, smask0);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d  = '0;
                    err_d  = err_sat;
                    bits_d = bits_q | diff;
                    if (diff != '0 && !fv_q) begin
                        fv_d = 1'b1;
                        ff_d = idx_q;
                    end
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(HOLD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_nxt;
                        a_d     = drive(stim_mem[idx_nxt], smask_mem[idx_nxt]);
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers, cleared immediately by nReset
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            a_q     <= '0;
            err_q   <= '0;
            bits_q  <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            a_q     <= a_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    assign bus.A         = a_q;
    assign bus.Busy      = busy;
    assign bus.Done      = (state_q == S_DONE);
    assign bus.Pass      = (state_q == S_DONE) && (err_q == '0);
    assign bus.ErrCount  = err_q;
    assign bus.ErrBits   = bits_q;
    assign bus.FailValid = fv_q;
    assign bus.FirstFail = ff_q;
endmodule

// File: tb/tb_vector_checker.sv
// Self-checking bench for vector_checker: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// closed-form timeline model of the run.
module tb_vector_checker;
    localparam int NI = 2, NO = 2, AW = 2, SE = 4, HO = 4, EW = 2;
    localparam int P = SE + HO;
    localparam int EMAX = (1 << EW) - 1;

    logic Clock, nReset;
    vector_checker_if #(.N_IN(NI), .N_OUT(NO), .ADDR_W(AW), .ERR_W(EW)) bus ();

    bit          qmode;
    logic [NO-1:0] qflip, qconst;
    assign bus.Q = qmode ? qconst : (~bus.A ^ qflip);

    vector_checker #(.N_IN(NI), .N_OUT(NO), .ADDR_W(AW), .SETTLE(SE), .HOLD(HO),
                     .ERR_W(EW), .MASK_STIM(1)) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0, passes = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        else passes++;
    endtask

    // ---------------- behavioural model ----------------
    logic [NI-1:0] t_stim [4], t_smask [4];
    logic [NO-1:0] t_exp [4], t_emask [4];
    logic [NI-1:0] sA [4];
    logic [NO-1:0] sd [4];
    int  cyc = 0, k = 0, L = 0;
    bit  rv = 1'b0;
    bit  m_idl;

    function automatic logic [NO-1:0] resp(input logic [NI-1:0] a);
        return qmode ? qconst : (~a ^ qflip);
    endfunction

    function automatic bit m_idle();
        return !rv || (cyc - k) >= (L + 1) * P;
    endfunction

    initial begin
        forever begin
            @(posedge Clock or negedge nReset);
            if (!nReset) rv = 1'b0;
            else begin
                m_idl = m_idle();
                if (bus.Load && m_idl) begin
                    t_stim[bus.LoadAddr]  = bus.StimIn;
                    t_smask[bus.LoadAddr] = bus.SMaskIn;
                    t_exp[bus.LoadAddr]   = bus.ExpIn;
                    t_emask[bus.LoadAddr] = bus.EMaskIn;
                end
                if (bus.Start && m_idl) begin
                    L = int'(bus.LastAddr);
                    for (int i = 0; i < 4; i++) begin
                        sA[i] = t_stim[i] & t_smask[i];
                        sd[i] = (resp(sA[i]) ^ t_exp[i]) & t_emask[i];
                    end
                    k  = cyc + 1;
                    rv = 1'b1;
                end
                cyc++;
            end
        end
    end

    task automatic model_out(output logic [NI-1:0] eA, output bit eBusy, output bit eDone,
                             output bit ePass, output int eErr, output logic [NO-1:0] eBits,
                             output bit eFv, output int eFf);
        int e, ai;
        eA = '0; eBusy = 0; eDone = 0; ePass = 0; eErr = 0; eBits = '0; eFv = 0; eFf = 0;
        if (rv) begin
            e     = cyc - k;
            eDone = (e >= (L + 1) * P);
            eBusy = !eDone;
            ai    = e / P;
            if (ai > L) ai = L;
            eA = sA[ai];
            for (int i = 0; i <= L; i++) begin
                if (i * P + SE <= e) begin
                    eErr += $countones(sd[i]);
                    eBits |= sd[i];
                    if (sd[i] != '0 && !eFv) begin
                        eFv = 1'b1;
                        eFf = i;
                    end
                end
            end
            if (eErr > EMAX) eErr = EMAX;
            ePass = eDone && (eErr == 0);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial begin
        logic [NI-1:0] eA;
        logic [NO-1:0] eBits;
        bit eBusy, eDone, ePass, eFv;
        int eErr, eFf;
        forever begin
            @(negedge Clock);
            if (cmp_en) begin
                model_out(eA, eBusy, eDone, ePass, eErr, eBits, eFv, eFf);
                chk("A", bus.A, eA);
                chk("Busy", bus.Busy, eBusy);
                chk("Done", bus.Done, eDone);
                chk("Pass", bus.Pass, ePass);
                chk("ErrCount", bus.ErrCount, eErr);
                chk("ErrBits", bus.ErrBits, eBits);
                chk("FailValid", bus.FailValid, eFv);
                chk("FirstFail", bus.FirstFail, eFf);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int a, input logic [NI-1:0] s, input logic [NI-1:0] sm,
                        input logic [NO-1:0] e, input logic [NO-1:0] em);
        @(negedge Clock);
        bus.Load = 1'b1; bus.LoadAddr = AW'(a);
        bus.StimIn = s; bus.SMaskIn = sm; bus.ExpIn = e; bus.EMaskIn = em;
        @(negedge Clock);
        bus.Load = 1'b0;
    endtask

    // Returns at the falling edge right after the Start edge k
    task automatic start(input int last);
        @(negedge Clock);
        bus.Start = 1'b1; bus.LastAddr = AW'(last);
        @(negedge Clock);
        bus.Start = 1'b0;
        bus.LastAddr = AW'($urandom);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        nReset = 1'b1;
        bus.Load = 0; bus.LoadAddr = '0; bus.StimIn = '0; bus.SMaskIn = '0;
        bus.ExpIn = '0; bus.EMaskIn = '0; bus.LastAddr = '0; bus.Start = 0;
        qmode = 0; qflip = '0; qconst = '0;
        #2 nReset = 1'b0;
        #10;
        chk("rst_A", bus.A, 0);
        chk("rst_Busy", bus.Busy, 0);
        chk("rst_Done", bus.Done, 0);
        chk("rst_Pass", bus.Pass, 0);
        chk("rst_ErrCount", bus.ErrCount, 0);
        chk("rst_ErrBits", bus.ErrBits, 0);
        chk("rst_FailValid", bus.FailValid, 0);
        chk("rst_FirstFail", bus.FirstFail, 0);
        @(negedge Clock);
        nReset = 1'b1;
        cmp_en = 1'b1;

        // Inverter pass
        load(0, 2'b00, 2'b11, 2'b11, 2'b11);
        load(1, 2'b11, 2'b11, 2'b00, 2'b11);
        load(2, 2'b01, 2'b11, 2'b10, 2'b11);
        load(3, 2'b10, 2'b11, 2'b01, 2'b11);
        start(1);
        chk("inv_A0", bus.A, 2'b00);
        wait_n(8);
        chk("inv_A1", bus.A, 2'b11);
        wait_n(7);
        chk("inv_busy15", bus.Busy, 1);
        chk("inv_done15", bus.Done, 0);
        wait_n(1);
        chk("inv_done16", bus.Done, 1);
        chk("inv_pass16", bus.Pass, 1);
        chk("inv_err16", bus.ErrCount, 0);

        // Stuck-at-0 outputs
        qmode = 1; qconst = 2'b00;
        start(1);
        wait_n(16);
        chk("stuck_err", bus.ErrCount, 2);
        chk("stuck_bits", bus.ErrBits, 2'b11);
        chk("stuck_fv", bus.FailValid, 1);
        chk("stuck_ff", bus.FirstFail, 0);
        chk("stuck_pass", bus.Pass, 0);

        // Compare mask hides vector 0
        load(0, 2'b00, 2'b11, 2'b11, 2'b00);
        start(1);
        wait_n(16);
        chk("mask_err", bus.ErrCount, 0);
        chk("mask_pass", bus.Pass, 1);

        // Saturation, then restart without reset
        for (int i = 0; i < 4; i++) load(i, NI'($urandom), 2'b11, 2'b01, 2'b01);
        start(3);
        wait_n(19);
        chk("sat_err19", bus.ErrCount, 2);
        wait_n(1);
        chk("sat_err20", bus.ErrCount, 3);
        wait_n(8);
        chk("sat_err28", bus.ErrCount, 3);
        wait_n(4);
        chk("sat_done", bus.Done, 1);
        start(3);
        chk("sat_restart_err", bus.ErrCount, 0);
        chk("sat_restart_done", bus.Done, 0);
        wait_n(32);

        // Reset mid-run
        load(0, 2'b11, 2'b11, 2'b00, 2'b11);
        load(1, 2'b00, 2'b11, 2'b11, 2'b11);
        qmode = 1; qconst = 2'b01;
        start(1);
        wait_n(4);
        chk("mr_err4", bus.ErrCount, 1);
        @(posedge Clock);
        #1 nReset = 1'b0;
        #1;
        chk("mr_A", bus.A, 0);
        chk("mr_busy", bus.Busy, 0);
        chk("mr_err", bus.ErrCount, 0);
        chk("mr_fv", bus.FailValid, 0);
        @(negedge Clock);
        nReset = 1'b1;
        start(1);
        chk("mr_rerun_A", bus.A, 2'b11);
        wait_n(16);
        chk("mr_rerun_err", bus.ErrCount, 2);
        chk("mr_rerun_bits", bus.ErrBits, 2'b11);

        // Start and Load while busy are ignored
        start(1);
        wait_n(2);
        bus.Start = 1; bus.Load = 1; bus.LoadAddr = '0;
        bus.StimIn = 2'b00; bus.SMaskIn = 2'b11; bus.ExpIn = 2'b10; bus.EMaskIn = 2'b11;
        @(negedge Clock);
        bus.Start = 0; bus.Load = 0;
        wait_n(12);
        chk("sb_busy15", bus.Busy, 1);
        wait_n(1);
        chk("sb_done16", bus.Done, 1);
        start(0);
        chk("sb_table_A", bus.A, 2'b11);
        wait_n(8);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge Clock);
            bus.Load     = ($urandom % 4 == 0);
            bus.LoadAddr = AW'($urandom);
            bus.StimIn   = NI'($urandom); bus.SMaskIn = NI'($urandom);
            bus.ExpIn    = NO'($urandom); bus.EMaskIn = NO'($urandom);
            bus.Start    = ($urandom % 10 == 0);
            bus.LastAddr = AW'($urandom);
            if (m_idle() && $urandom % 4 == 0) begin
                qmode = 1'($urandom); qflip = NO'($urandom); qconst = NO'($urandom);
            end
            if ($urandom % 300 == 0) begin
                #2 nReset = 1'b0;
                @(negedge Clock);
                #2 nReset = 1'b1;
            end
        end
        @(negedge Clock);
        bus.Load = 0; bus.Start = 0;
        wait_n(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable on-chip counterpart of the D2 vector test bench. It holds a small table of stimulus/expected vectors and applies each stimulus to the chip-under-test inputs. After a settle interval it samples the chip outputs, compares them under mask, and accumulates error counts. It sits between the D2 chip pins and the lab host interface, and reports pass/fail plus first-failing vector.

## Interface
- N_IN, 1, stimulus width (DUT inputs)
- N_OUT, 1, response width (DUT outputs)
- ADDR_W, 2, vector table address width; DEPTH = 2**ADDR_W entries
- SETTLE, 4, clock cycles from stimulus change to response sample (≥1)
- HOLD, 4, clock cycles after sample before next stimulus (≥1)
- ERR_W, 8, error counter width
- MASK_STIM, 0, 1 = drive stim & stim_mask, 0 = drive stim unmasked

- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- Load  in  1  write vector table entry this cycle
- LoadAddr  in  ADDR_W  entry address
- StimIn / SMaskIn  in  N_IN each  stimulus and stimulus mask
- ExpIn / EMaskIn  in  N_OUT each  expected response and compare mask
- LastAddr  in  ADDR_W  index of last vector to run, sampled at Start
- Start  in  1  begin run, single-cycle pulse
- A  out  N_IN  stimulus to DUT inputs
- Q  in  N_OUT  DUT response, assumed stable by sample edge
- Busy  out  1  run in progress
- Done  out  1  run complete, sticky
- Pass  out  1  Done & (ErrCount == 0)
- ErrCount  out  ERR_W  total mismatching bits, saturating
- ErrBits  out  N_OUT  sticky per-output-bit error flags
- FailValid  out  1  at least one vector failed
- FirstFail  out  ADDR_W  index of first failing vector

## Operation
- States: IDLE, SETTLE, HOLD, DONE.
- **IDLE/DONE**
  - Load writes {Stim, SMask, Exp, EMask} at LoadAddr.
  - Load while Busy is ignored.
  - Start takes effect here. It clears ErrCount, ErrBits, FailValid, FirstFail and Done, latches LastAddr, sets idx=0, drives A from vector 0, and enters SETTLE.
- **SETTLE**
  - Count SETTLE cycles.
  - On the last SETTLE edge, form diff = (Q ^ Exp[idx]) & EMask[idx].
  - ErrCount += popcount(diff), clamped at 2**ERR_W−1.
  - ErrBits |= diff.
  - If diff ≠ 0 and !FailValid: FirstFail=idx and FailValid=1.
  - Then enter HOLD.
- **HOLD**
  - Count HOLD cycles.
  - On the last HOLD edge: if idx == latched LastAddr, go to DONE and set Done=1. Otherwise idx+1, apply the next stimulus to A, and re-enter SETTLE.
- A holds its last driven value in IDLE/DONE.
- Busy=1 in SETTLE and HOLD.
- Start while Busy is ignored.
- MASK_STIM=1: A = Stim & SMask (x-to-0 mode).
- The vector table is not reset. Contents survive nReset.

## Timing
- Reset values: A=0, Busy=0, Done=0, Pass=0, ErrCount=0, ErrBits=0, FailValid=0, FirstFail=0, state IDLE.
- Reset is asynchronous and applies immediately, including mid-run. After release the block is in IDLE and needs a new Start.
- Let edge k be the edge where Start is sampled.
  - Vector i is applied on A at edge k + i·(SETTLE+HOLD).
  - Its response is sampled at edge k + i·(SETTLE+HOLD) + SETTLE.
  - Error outputs update at that same edge.
- Done and Pass are visible after edge k + (LastAddr+1)·(SETTLE+HOLD). Busy falls at the same edge.
- LastAddr changes during a run have no effect.
- ErrCount at its maximum stays at maximum.
- Load and Start in the same IDLE cycle: the write completes, and the run reads the new entry.

## Test plan
- **Inverter pass:** load {0→1}, {1→0}, all masks 1, LastAddr=1, Q=~A, SETTLE=HOLD=4, Start at edge k.
  - A=0 at k and A=1 at k+8.
  - Done=1, Pass=1 and ErrCount=0 after k+16.
- **Stuck fault:** same vectors, Q tied 0.
  - ErrCount=1, ErrBits=1, FailValid=1, FirstFail=0, Pass=0.
- **Compare mask:** Q tied 0, EMask of vector 0 = 0.
  - ErrCount=0, Pass=1.
- **Saturation:** ERR_W=2, DEPTH=4, all four vectors mismatching, plus a second Start without reset.
  - ErrCount stops at 3 on the 4th sample.
  - The second Start clears ErrCount to 0 first.
- **Reset mid-run:** assert nReset low at edge k+5 of a 2-vector run.
  - All outputs return to reset values immediately.
  - The next Start reruns from vector 0 using the retained table.
- **Start while Busy:** pulse Start at k+3.
  - It is ignored and the run timing is unchanged.
  - Load at k+3 does not alter the table.
